nlfsr128_keystream_core: RTL
============================

// Module: nlfsr128_keystream_core
// PURPOSE
//  Downstream consumer of the 128-bit ADC seed generator. Loads {seed1,seed2} into a 128-bit NLFSR,
//  runs a warm-up, then emits 32-bit random words over a valid/ready handshake. Auto-reseeds after a
//  programmable word count. Live NLFSR state is exported as seedloop and fed back to the generator.
// PARAMETERS
//  WARMUP_CYCLES    128  NLFSR steps after seed load before the first word (>=1)
//  RESEED_INTERVAL  4096 words accepted before an automatic reseed; 0 = never
//  REP_LIMIT        4    identical consecutive words that trip health_fail (RNG_HEALTH_EN only, >=2)
// PORTS
//  clk          in   1    system clock, rising edge
//  rst          in   1    asynchronous active-high reset
//  seed1        in   64   seed high half, sampled in LOAD
//  seed2        in   64   seed low half, sampled in LOAD
//  reseed_req   in   1    level/pulse request to reload the seed; sampled every cycle
//  rnd_ready    in   1    consumer ready
//  rnd_valid    out  1    rnd_data holds an unconsumed word
//  rnd_data     out  32   random word
//  seedloop     out  128  current NLFSR state s
//  busy         out  1    high in LOAD or WARMUP
//  health_fail  out  1    sticky health alarm (0 when RNG_HEALTH_EN is undefined)
// BEHAVIOUR
//  Reset: fsm=IDLE; s=128'h1; rnd_valid=0; rnd_data=0; busy=0; health_fail=0; counters=0.
//  Step: f = s[127]^s[125]^s[100]^s[98]^s[0]^(s[60]&s[62])^(s[31]&s[45]); s_next = {s[126:0], f}.
//  FSM:
//   IDLE   : s held; reseed_req=1 -> LOAD.
//   LOAD   : one cycle; s <= {seed1,seed2}, or 128'h1 if that value is zero (avoids all-zero lock);
//            warmup cnt <= 0; rnd_valid <= 0 -> WARMUP.
//   WARMUP : one step per cycle; after WARMUP_CYCLES steps -> RUN.
//   RUN    : if (!rnd_valid || rnd_ready): rnd_data <= s[127:96]^s[63:32] (pre-step s);
//            s <= step(s); rnd_valid <= 1; else hold everything (including s).
//  Latency: rnd_valid rises at edge WARMUP_CYCLES+2 after the edge that samples reseed_req.
//  Handshake: a transfer occurs when rnd_valid && rnd_ready. rnd_data is stable while valid && !ready.
//   Back-to-back transfers occur at one word per cycle.
//  Word count: increments on each transfer. When RESEED_INTERVAL != 0 and count reaches
//   RESEED_INTERVAL, the next state is LOAD (the word transferred that cycle is completed), and the count clears.
//  reseed_req in WARMUP/RUN -> LOAD next cycle. rnd_valid drops in LOAD, and any unconsumed word is
//   discarded. reseed_req in LOAD is ignored.
//  busy = (fsm==LOAD || fsm==WARMUP), registered with fsm.
//  rst asserted mid-operation: all state returns to reset values immediately (async).
// CONFIGURATION
//  RNG_HEALTH_EN defined:
//   - Repetition-count test on words as they are loaded into rnd_data in RUN.
//   - A run of REP_LIMIT identical consecutive words sets health_fail=1 and forces LOAD.
//   - health_fail is sticky until rst; the run count clears on LOAD.
//  RNG_HEALTH_EN undefined: no test logic; health_fail tied to 0.
// TESTING
//  1. rst, then seed1=0, seed2=0, reseed_req pulse -> s=128'h1 after LOAD; busy high for 1+WARMUP_CYCLES
//     cycles; rnd_valid rises WARMUP_CYCLES+2 edges after the req edge.
//  2. seed1=64'h0123456789ABCDEF, seed2=64'hFEDCBA9876543210, rnd_ready=1 -> rnd_data sequence
//     matches the reference step model word for word for 1000 words, one word per cycle.
//  3. Back-pressure: rnd_ready low for 10 cycles in RUN -> rnd_data, rnd_valid and seedloop frozen;
//     stream resumes with no word lost or duplicated.
//  4. RESEED_INTERVAL=8, rnd_ready=1 -> after the 8th transfer, LOAD occurs; seedloop = new
//     {seed1,seed2}; rnd_valid low for WARMUP_CYCLES+1 cycles.
//  5. reseed_req mid-WARMUP and mid-RUN with a pending word -> word dropped, LOAD next cycle;
//     async rst mid-RUN -> all outputs at reset values.
//  6. RNG_HEALTH_EN with a forced stuck model (force s to 0 in RUN) -> health_fail=1 after the REP_LIMIT-th
//     identical word and remains 1 after the reseed; without the macro health_fail stays 0.

Source files
------------

// File: rtl/nlfsr128_keystream_core_if.sv
// nlfsr128_keystream_core_if: seed load, reseed request and 32-bit word handshake of the keystream core
interface nlfsr128_keystream_core_if;
  logic [63:0]  seed1;
  logic [63:0]  seed2;
  logic         reseed_req;
  logic         rnd_ready;
  logic         rnd_valid;
  logic [31:0]  rnd_data;
  logic [127:0] seedloop;
  logic         busy;
  logic         health_fail;
  modport master (output seed1, seed2, reseed_req, rnd_ready,
                  input  rnd_valid, rnd_data, seedloop, busy, health_fail);
  modport slave  (input  seed1, seed2, reseed_req, rnd_ready,
                  output rnd_valid, rnd_data, seedloop, busy, health_fail);
endinterface

// File: rtl/nlfsr128_keystream_core.sv
// nlfsr128_keystream_core: 128-bit NLFSR keystream with warm-up, auto-reseed and valid/ready output.
// Define RNG_HEALTH_EN to add the repetition-count health test (sticky health_fail).
module nlfsr128_keystream_core #(
  parameter int WARMUP_CYCLES   = 128,
  parameter int RESEED_INTERVAL = 4096,
  parameter int REP_LIMIT       = 4
) (
  input logic clk,
  input logic rst,
  nlfsr128_keystream_core_if.slave bus
);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;
  state_t        state_q, state_d;
  logic [127:0]  s_q, seed;
  logic [WW-1:0] warm_q;
  logic [31:0]   wcnt_q, data_q, word;
  logic          valid_q, busy_q, gen, xfer, wrap, rep_trip;
  if (WARMUP_CYCLES < 1 || REP_LIMIT < 2) begin : g_bad_param
    $error("nlfsr128_keystream_core: WARMUP_CYCLES must be >=1 and REP_LIMIT >=2");
  end
  function automatic logic [127:0] step(input logic [127:0] s);
    return {s[126:0], s[127] ^ s[125] ^ s[100] ^ s[98] ^ s[0] ^ (s[60] & s[62]) ^ (s[31] & s[45])};
  endfunction
  assign word = s_q[127:96] ^ s_q[63:32];
  assign seed = {bus.seed1, bus.seed2};
  assign gen  = state_q == RUN && (!valid_q || bus.rnd_ready);
  assign xfer = state_q == RUN && valid_q && bus.rnd_ready;
  assign wrap = xfer && RESEED_INTERVAL != 0 && wcnt_q == 32'(RESEED_INTERVAL - 1);
  assign state_d = state_q == IDLE ? (bus.reseed_req ? LOAD : IDLE)
                 : state_q == LOAD ? WARMUP
                 : (bus.reseed_req || wrap || rep_trip) ? LOAD
                 : (state_q == WARMUP && warm_q == WW'(WARMUP_CYCLES - 1)) ? RUN
                 : state_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 128'h1;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      warm_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= state_d == LOAD || state_d == WARMUP;
      if (state_q == LOAD) begin
        s_q     <= seed == '0 ? 128'h1 : seed;
        warm_q  <= '0;
        valid_q <= 1'b0;
        wcnt_q  <= '0;
      end
      if (state_q == WARMUP) begin
        s_q    <= step(s_q);
        warm_q <= warm_q + WW'(1);
      end
      // the word is taken from the pre-step state, then the register advances
      if (gen) begin
        data_q  <= word;
        s_q     <= step(s_q);
        valid_q <= 1'b1;
      end
      if (xfer) wcnt_q <= wrap ? '0 : wcnt_q + 32'd1;
    end
  end
`ifdef RNG_HEALTH_EN
  localparam int RW = $clog2(REP_LIMIT + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic          hf_q;
  // rep_q == 0 marks a fresh run after LOAD, so the first word never matches stale data
  assign rep_d    = (rep_q != '0 && word == data_q) ? rep_q + RW'(1) : RW'(1);
  assign rep_trip = gen && rep_d == RW'(REP_LIMIT);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q <= '0;
      hf_q  <= 1'b0;
    end else begin
      if (state_q == LOAD) rep_q <= '0;
      else if (gen) rep_q <= rep_d;
      if (rep_trip) hf_q <= 1'b1;
    end
  end
  assign bus.health_fail = hf_q;
`else
  assign rep_trip        = 1'b0;
  assign bus.health_fail = 1'b0;
`endif
  assign bus.rnd_valid = valid_q;
  assign bus.rnd_data  = data_q;
  assign bus.seedloop  = s_q;
  assign bus.busy      = busy_q;
endmodule
